mem_seq: RTL and testbench
==========================

Name: mem_seq

Overview:
- Parametrised byte-serial load/store sequencer for an 8-bit-wide memory, serving a CPU core.
- Converts one byte/word/long request into a big-endian sequence of byte reads or byte write strobes.
- Generalises the CPU's hard-wired LOADB/W/L and STORB/W/L state chains:
  - configurable data width and read latency;
  - honours mem_ready stalls;
  - optional sign extension.

Parameters:
ADDR_WIDTH, 9, width of memory byte addresses
DATA_BYTES, 4, maximum transfer size in bytes (power of two, 1..8)
READ_LATENCY, 2, clock edges from mem_raddr update to mem_data_out capture (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; transfer accepted on edge where req_valid&&req_ready
req_write  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=word(2), 2=long(4), 3=quad(8)
req_signed  in  1  load result sign-extended (see Optional Feature)
req_addr  in  ADDR_WIDTH  address of most significant byte
req_wdata  in  8*DATA_BYTES  store data; low N bytes used
resp_valid  out  1  one-cycle pulse: load data valid / store complete
resp_err  out  1  qualified by resp_valid; size exceeds DATA_BYTES
resp_rdata  out  8*DATA_BYTES  load result, right-aligned, held until next load
busy  out  1  high whenever not IDLE
mem_raddr  out  ADDR_WIDTH  memory read address
mem_waddr  out  ADDR_WIDTH  memory write address
mem_data_in  out  8  byte to memory
mem_write  out  1  one-cycle write strobe
mem_data_out  in  8  byte from memory
mem_ready  in  1  low = memory stall

Behaviour:
- Reset (async, reset_n=0): state=IDLE. All outputs 0, except req_ready=1. Any in-flight transfer is abandoned; mem_write drops immediately.
- N = 1<<req_size, latched at accept.
- Error case (N>DATA_BYTES):
  - no memory access;
  - next cycle resp_valid=1, resp_err=1; resp_rdata unchanged.
- States: IDLE, RD, WR_SETUP, WR_STROBE, DONE.
- Load:
  - Accept edge E0: mem_raddr<=req_addr, byte counter=0, latency counter=0.
  - Byte i is captured at edge E0+(i+1)*READ_LATENCY, shifted in MSB-first. The same edge advances mem_raddr by 1 unless it is the last byte.
  - The last capture edge sets resp_valid and returns to IDLE.
  - Example, READ_LATENCY=2, N=4: resp_valid high in the cycle after E0+8.
- Store:
  - Accept edge E0: mem_waddr<=req_addr, mem_data_in<=most significant of the N used bytes; enter WR_STROBE.
  - Each WR_STROBE edge: mem_write=1.
  - Each following WR_SETUP edge: mem_waddr+1, next byte loaded.
  - mem_write is high after edges E0+1, E0+3, ..., E0+2N-1.
  - resp_valid is high after edge E0+2N.
- Addresses wrap modulo 2^ADDR_WIDTH, no error.
- Stall (mem_ready=0 in any non-IDLE state):
  - counters, addresses and state freeze;
  - no capture; mem_write forced 0.
  - Progress resumes on the first edge with mem_ready=1.
  - In IDLE, mem_ready is ignored.
- resp_valid coincides with IDLE, so req_ready=1 in the same cycle: back-to-back requests are allowed with zero bubble.
- req_* are sampled only at accept; later changes have no effect.
- resp_rdata:
  - loads with N<DATA_BYTES are zero-filled above byte N-1, or sign-filled if enabled;
  - stores leave resp_rdata unchanged.

Optional Feature:
- MEM_SEQ_SIGNEXT_EN defined: when req_signed=1, the load result is sign-extended from bit 8N-1 to 8*DATA_BYTES.
- Undefined: req_signed ignored; always zero-extended.

Decomposition:
- Package mem_seq_pkg holds:
  - size encodings SIZE_BYTE/WORD/LONG/QUAD;
  - state encodings;
  - function size_to_bytes.
- One sub-module, mem_seq_extend: combinational zero/sign extension of the assembled shift register by N. Only its sign path depends on MEM_SEQ_SIGNEXT_EN.

Test Plan:
- Long load, memory[0x10..0x13]=80 12 34 56, READ_LATENCY=2 -> mem_raddr 0x10..0x13; resp_valid 8 cycles after accept; resp_rdata=0x80123456.
- Word load at 0x20 = FF 7F, req_signed=1 -> 0xFFFFFF7F with MEM_SEQ_SIGNEXT_EN, 0x0000FF7F without.
- Long store 0xDEADBEEF to 0x1FE (ADDR_WIDTH=9) -> writes DE@0x1FE, AD@0x1FF, BE@0x000, EF@0x001; four mem_write pulses; resp_valid at E0+8.
- Byte load with mem_ready low for 3 cycles mid-wait -> no capture during the stall; resp_valid delayed exactly 3 cycles; data correct.
- req_size=3 with DATA_BYTES=4 -> no mem_write, no mem_raddr change; resp_valid=1, resp_err=1 one cycle after accept.
- reset_n pulsed low during the 2nd byte of a long store -> mem_write 0 immediately; busy=0; req_ready=1; no further writes after release.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared encodings and helpers for the mem_seq byte-serial load/store sequencer.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_WORD = 2'd1,
    SIZE_LONG = 2'd2,
    SIZE_QUAD = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_DONE
  } state_e;

  function automatic logic [3:0] size_to_bytes(input logic [1:0] size);
    logic [3:0] n;
    unique case (size_e'(size))
      SIZE_BYTE: n = 4'd1;
      SIZE_WORD: n = 4'd2;
      SIZE_LONG: n = 4'd4;
      default:   n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_seq_extend.sv
// Zero/sign extension of an assembled load value to the full data width.
// Sign fill only exists when MEM_SEQ_SIGNEXT_EN is defined.
module mem_seq_extend
  import mem_seq_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4
) (
  input  logic [8*DATA_BYTES-1:0] i_data,
  input  logic [1:0]              i_size,
  input  logic                    i_signed,
  output logic [8*DATA_BYTES-1:0] o_data
);

  logic [3:0] w_nbytes;
  logic       w_sign;
  logic       w_fill_en;

  always_comb begin
    w_nbytes = size_to_bytes(i_size);
    w_sign   = 1'b0;
    for (int unsigned k = 0; k < DATA_BYTES; k++) begin
      if (4'(k + 1) == w_nbytes) w_sign = i_data[8*k+7];
    end
  end

`ifdef MEM_SEQ_SIGNEXT_EN
  assign w_fill_en = i_signed & w_sign;
`else
  logic w_signext_unused;
  assign w_signext_unused = i_signed ^ w_sign;
  assign w_fill_en        = 1'b0;
`endif

  always_comb begin
    o_data = '0;
    for (int unsigned k = 0; k < DATA_BYTES; k++) begin
      o_data[8*k +: 8] = (4'(k) < w_nbytes) ? i_data[8*k +: 8] : {8{w_fill_en}};
    end
  end

endmodule

// File: rtl/mem_seq.sv
// Byte-serial big-endian load/store sequencer for an 8-bit memory.
// Optional sign extension of loads under MEM_SEQ_SIGNEXT_EN.
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned DATA_BYTES   = 4,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    resp_valid,
  output logic                    resp_err,
  output logic [8*DATA_BYTES-1:0] resp_rdata,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   mem_raddr,
  output logic [ADDR_WIDTH-1:0]   mem_waddr,
  output logic [7:0]              mem_data_in,
  output logic                    mem_write,
  input  logic [7:0]              mem_data_out,
  input  logic                    mem_ready
);

  localparam int unsigned   DW        = 8 * DATA_BYTES;
  localparam int unsigned   LW        = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [3:0]    MAX_BYTES = 4'(DATA_BYTES);
  localparam logic [LW-1:0] LAT_LAST  = LW'(READ_LATENCY - 1);

  state_e                r_state,  w_state_nx;
  logic [ADDR_WIDTH-1:0] r_raddr,  w_raddr_nx;
  logic [ADDR_WIDTH-1:0] r_waddr,  w_waddr_nx;
  logic [7:0]            r_din,    w_din_nx;
  logic                  r_write,  w_write_nx;
  logic                  r_rv,     w_rv_nx;
  logic                  r_err,    w_err_nx;
  logic                  r_errp,   w_errp_nx;
  logic [DW-1:0]         r_rdata,  w_rdata_nx;
  logic [DW-1:0]         r_shift,  w_shift_nx;
  logic [DW-1:0]         r_wdata,  w_wdata_nx;
  logic [1:0]            r_size,   w_size_nx;
  logic [3:0]            r_nbytes, w_nbytes_nx;
  logic                  r_signed, w_signed_nx;
  logic [2:0]            r_cnt,    w_cnt_nx;
  logic [LW-1:0]         r_lat,    w_lat_nx;

  logic [3:0]    w_req_n;
  logic [DW-1:0] w_byte_ext;
  logic [DW-1:0] w_shift_cap;
  logic [DW-1:0] w_ext;

  function automatic logic [7:0] pick_byte(input logic [DW-1:0] d, input logic [2:0] idx);
    logic [7:0] b;
    b = '0;
    for (int unsigned k = 0; k < DATA_BYTES; k++) begin
      if (idx == 3'(k)) b = d[8*k +: 8];
    end
    return b;
  endfunction

  always_comb begin
    w_req_n           = size_to_bytes(req_size);
    w_byte_ext        = '0;
    w_byte_ext[7:0]   = mem_data_out;
    w_shift_cap       = (r_shift << 8) | w_byte_ext;
  end

  mem_seq_extend #(
    .DATA_BYTES (DATA_BYTES)
  ) u_extend (
    .i_data   (w_shift_cap),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ext)
  );

  // Every non-IDLE branch is gated by mem_ready so a stall freezes all state.
  always_comb begin
    w_state_nx  = r_state;
    w_raddr_nx  = r_raddr;
    w_waddr_nx  = r_waddr;
    w_din_nx    = r_din;
    w_write_nx  = 1'b0;
    w_rv_nx     = 1'b0;
    w_err_nx    = 1'b0;
    w_errp_nx   = r_errp;
    w_rdata_nx  = r_rdata;
    w_shift_nx  = r_shift;
    w_wdata_nx  = r_wdata;
    w_size_nx   = r_size;
    w_nbytes_nx = r_nbytes;
    w_signed_nx = r_signed;
    w_cnt_nx    = r_cnt;
    w_lat_nx    = r_lat;

    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_size_nx   = req_size;
          w_nbytes_nx = w_req_n;
          w_signed_nx = req_signed;
          w_cnt_nx    = '0;
          w_errp_nx   = 1'b0;
          if (w_req_n > MAX_BYTES) begin
            w_errp_nx  = 1'b1;
            w_state_nx = ST_DONE;
          end else if (req_write) begin
            w_waddr_nx = req_addr;
            w_wdata_nx = req_wdata;
            w_din_nx   = pick_byte(req_wdata, 3'(w_req_n - 4'd1));
            w_state_nx = ST_WR_STROBE;
          end else begin
            w_raddr_nx = req_addr;
            w_lat_nx   = '0;
            w_shift_nx = '0;
            w_state_nx = ST_RD;
          end
        end
      end

      ST_RD: begin
        if (mem_ready) begin
          if (r_lat == LAT_LAST) begin
            w_lat_nx   = '0;
            w_shift_nx = w_shift_cap;
            if ({1'b0, r_cnt} == r_nbytes - 4'd1) begin
              w_rdata_nx = w_ext;
              w_rv_nx    = 1'b1;
              w_state_nx = ST_IDLE;
            end else begin
              w_cnt_nx   = r_cnt + 3'd1;
              w_raddr_nx = r_raddr + ADDR_WIDTH'(1);
            end
          end else begin
            w_lat_nx = r_lat + LW'(1);
          end
        end
      end

      ST_WR_STROBE: begin
        if (mem_ready) begin
          w_write_nx = 1'b1;
          w_state_nx = ({1'b0, r_cnt} == r_nbytes - 4'd1) ? ST_DONE : ST_WR_SETUP;
        end
      end

      ST_WR_SETUP: begin
        if (mem_ready) begin
          w_cnt_nx   = r_cnt + 3'd1;
          w_waddr_nx = r_waddr + ADDR_WIDTH'(1);
          w_din_nx   = pick_byte(r_wdata, 3'(r_nbytes - 4'd2 - {1'b0, r_cnt}));
          w_state_nx = ST_WR_STROBE;
        end
      end

      ST_DONE: begin
        if (mem_ready) begin
          w_rv_nx    = 1'b1;
          w_err_nx   = r_errp;
          w_state_nx = ST_IDLE;
        end
      end

      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_raddr  <= '0;
      r_waddr  <= '0;
      r_din    <= '0;
      r_write  <= 1'b0;
      r_rv     <= 1'b0;
      r_err    <= 1'b0;
      r_errp   <= 1'b0;
      r_rdata  <= '0;
      r_shift  <= '0;
      r_wdata  <= '0;
      r_size   <= '0;
      r_nbytes <= '0;
      r_signed <= 1'b0;
      r_cnt    <= '0;
      r_lat    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_raddr  <= w_raddr_nx;
      r_waddr  <= w_waddr_nx;
      r_din    <= w_din_nx;
      r_write  <= w_write_nx;
      r_rv     <= w_rv_nx;
      r_err    <= w_err_nx;
      r_errp   <= w_errp_nx;
      r_rdata  <= w_rdata_nx;
      r_shift  <= w_shift_nx;
      r_wdata  <= w_wdata_nx;
      r_size   <= w_size_nx;
      r_nbytes <= w_nbytes_nx;
      r_signed <= w_signed_nx;
      r_cnt    <= w_cnt_nx;
      r_lat    <= w_lat_nx;
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign resp_valid  = r_rv;
  assign resp_err    = r_err;
  assign resp_rdata  = r_rdata;
  assign mem_raddr   = r_raddr;
  assign mem_waddr   = r_waddr;
  assign mem_data_in = r_din;
  assign mem_write   = r_write;

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq with a registered-read byte memory model.
module tb_mem_seq;

  localparam int unsigned AW = 9;
  localparam int unsigned DB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic            req_valid, req_ready, req_write, req_signed;
  logic [1:0]      req_size;
  logic [AW-1:0]   req_addr;
  logic [8*DB-1:0] req_wdata;
  logic            resp_valid, resp_err, busy;
  logic [8*DB-1:0] resp_rdata;
  logic [AW-1:0]   mem_raddr, mem_waddr;
  logic [7:0]      mem_data_in, mem_data_out;
  logic            mem_write, mem_ready;

  mem_seq #(
    .ADDR_WIDTH   (AW),
    .DATA_BYTES   (DB),
    .READ_LATENCY (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .busy         (busy),
    .mem_raddr    (mem_raddr),
    .mem_waddr    (mem_waddr),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write),
    .mem_data_out (mem_data_out),
    .mem_ready    (mem_ready)
  );

  logic [7:0]    mem [0:(1<<AW)-1];
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;
  int unsigned   n_wr = 0;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (mem_write) begin
      mem[mem_waddr] <= mem_data_in;
      n_wr <= n_wr + 1;
    end
    mem_data_out <= mem[mem_raddr];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_we = 1'b0;
  endtask

  // Present a request for one edge (the accept edge E0), then scramble req_*.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [AW-1:0] a, input logic [8*DB-1:0] wd);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    tick();
    req_valid = 1'b0; req_write = ~wr; req_size = 2'd0; req_signed = ~sg;
    req_addr = ~a; req_wdata = ~wd;
  endtask

  logic [31:0] exp_w;
  int unsigned wr_snap;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = '0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; mem_ready = 1'b1;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    tick(); tick();

    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_raddr", mem_raddr, 0);
    check("rst_rdata", resp_rdata, 0);
    #2 reset_n = 1'b1;

    preload(9'h010, 8'h80); preload(9'h011, 8'h12);
    preload(9'h012, 8'h34); preload(9'h013, 8'h56);
    preload(9'h020, 8'hFF); preload(9'h021, 8'h7F);
    preload(9'h030, 8'hA5);
    preload(9'h040, 8'h00); preload(9'h041, 8'h00);

    // Long load, latency 2
    issue(1'b0, 2'd2, 1'b0, 9'h010, '0);
    check("ld_raddr0", mem_raddr, 9'h010);
    check("ld_busy", busy, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 2) check("ld_raddr1", mem_raddr, 9'h011);
      if (i == 4) check("ld_raddr2", mem_raddr, 9'h012);
      if (i == 6) check("ld_raddr3", mem_raddr, 9'h013);
      if (i == 7) check("ld_rv_early", resp_valid, 0);
    end
    check("ld_rv", resp_valid, 1);
    check("ld_err", resp_err, 0);
    check("ld_rdata", resp_rdata, 32'h80123456);
    check("ld_ready_b2b", req_ready, 1);

    // Signed word load
    issue(1'b0, 2'd1, 1'b1, 9'h020, '0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 3) check("ldw_rv_early", resp_valid, 0);
    end
`ifdef MEM_SEQ_SIGNEXT_EN
    exp_w = 32'hFFFFFF7F;
`else
    exp_w = 32'h0000FF7F;
`endif
    check("ldw_rv", resp_valid, 1);
    check("ldw_rdata", resp_rdata, exp_w);

    // Long store with address wrap
    wr_snap = n_wr;
    issue(1'b1, 2'd2, 1'b0, 9'h1FE, 32'hDEADBEEF);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("st_strobe%0d", i), mem_write, (i % 2 == 1) ? 1 : 0);
      if (i == 1) begin check("st_wa0", mem_waddr, 9'h1FE); check("st_d0", mem_data_in, 8'hDE); end
      if (i == 3) begin check("st_wa1", mem_waddr, 9'h1FF); check("st_d1", mem_data_in, 8'hAD); end
      if (i == 5) begin check("st_wa2", mem_waddr, 9'h000); check("st_d2", mem_data_in, 8'hBE); end
      if (i == 7) begin check("st_wa3", mem_waddr, 9'h001); check("st_d3", mem_data_in, 8'hEF); end
      if (i == 7) check("st_rv_early", resp_valid, 0);
    end
    check("st_rv", resp_valid, 1);
    check("st_rdata_kept", resp_rdata, exp_w);
    check("st_nwr", n_wr - wr_snap, 4);
    check("st_m1fe", mem[9'h1FE], 8'hDE);
    check("st_m1ff", mem[9'h1FF], 8'hAD);
    check("st_m000", mem[9'h000], 8'hBE);
    check("st_m001", mem[9'h001], 8'hEF);

    // Byte load with a 3-cycle stall
    issue(1'b0, 2'd0, 1'b0, 9'h030, '0);
    mem_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 3) mem_ready = 1'b1;
      if (i == 2) begin check("stall_busy", busy, 1); check("stall_rv", resp_valid, 0); end
      if (i == 4) check("stall_rv_early", resp_valid, 0);
    end
    check("stall_rv_late", resp_valid, 1);
    check("stall_rdata", resp_rdata, 32'h000000A5);

    // Oversize request
    wr_snap = n_wr;
    issue(1'b1, 2'd3, 1'b0, 9'h055, 32'h01020304);
    check("err_rv_early", resp_valid, 0);
    check("err_mem_write0", mem_write, 0);
    tick();
    check("err_rv", resp_valid, 1);
    check("err_flag", resp_err, 1);
    check("err_raddr", mem_raddr, 9'h030);
    check("err_rdata", resp_rdata, 32'h000000A5);
    check("err_nwr", n_wr - wr_snap, 0);
    tick();
    check("err_clear", resp_err, 0);

    // Reset during the second byte of a long store
    issue(1'b1, 2'd2, 1'b0, 9'h040, 32'h11223344);
    for (int i = 1; i <= 3; i++) tick();
    check("rs_strobe2", mem_write, 1);
    #1 reset_n = 1'b0;
    #1;
    check("rs_mem_write", mem_write, 0);
    check("rs_busy", busy, 0);
    check("rs_req_ready", req_ready, 1);
    wr_snap = n_wr;
    tick(); tick();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("rs_nwr", n_wr - wr_snap, 0);
    check("rs_m040", mem[9'h040], 8'h11);
    check("rs_m041", mem[9'h041], 8'h00);
    check("rs_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
